// File: rtl/mips_cpu_bus_muldiv_unit.sv
// Iterative multiply/divide unit holding the HI/LO pair for the bus CPU.
// One shift-add or restoring shift-subtract step per cycle, sign fix-up at the end.
module mips_cpu_bus_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [CW-1:0]    control_alu,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNTW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  localparam logic [CW-1:0] OP_DIVU  = CW'(4);
  localparam logic [CW-1:0] OP_DIV   = CW'(5);
  localparam logic [CW-1:0] OP_MULTU = CW'(7);
  localparam logic [CW-1:0] OP_MULT  = CW'(8);
  localparam logic [CW-1:0] OP_MTLO  = CW'(18);
  localparam logic [CW-1:0] OP_MTHI  = CW'(19);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t               state_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [WIDTH-1:0]     m_reg;
  logic [CNTW-1:0]      cnt_reg;
  logic                 is_div_reg;
  logic                 sign_a_reg;
  logic                 sign_b_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 div_zero_reg;
  logic [WIDTH-1:0]     hi_reg;
  logic [WIDTH-1:0]     lo_reg;

  logic                 req_signed;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       rem_sub;
  logic                 rem_ge;
  logic [2*WIDTH-1:0]   step_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;

  always_comb begin
    req_signed = (control_alu == OP_DIV) || (control_alu == OP_MULT);
    abs_a      = (req_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    abs_b      = (req_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift right keeping the carry.
    mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? m_reg : {WIDTH{1'b0}})};

    // Divide: shift remainder:quotient left by one and try to subtract.
    rem_sh  = acc_reg[2*WIDTH-1:WIDTH-1];
    rem_ge  = rem_sh >= {1'b0, m_reg};
    rem_sub = rem_sh - {1'b0, m_reg};

    if (is_div_reg)
      step_next = {(rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_reg[WIDTH-2:0], rem_ge};
    else
      step_next = {mul_sum, acc_reg[WIDTH-1:1]};

    prod_fix = (sign_a_reg != sign_b_reg) ? -acc_reg : acc_reg;
    quot_fix = (sign_a_reg != sign_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix  = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      acc_reg      <= '0;
      m_reg        <= '0;
      cnt_reg      <= '0;
      is_div_reg   <= 1'b0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (op_valid) begin
            case (control_alu)
              OP_MTHI: hi_reg <= op_a;
              OP_MTLO: lo_reg <= op_a;
              OP_MULT, OP_MULTU: begin
                acc_reg    <= {{WIDTH{1'b0}}, abs_b};
                m_reg      <= abs_a;
                cnt_reg    <= '0;
                is_div_reg <= 1'b0;
                sign_a_reg <= req_signed && op_a[WIDTH-1];
                sign_b_reg <= req_signed && op_b[WIDTH-1];
                busy_reg   <= 1'b1;
                state_reg  <= S_RUN;
              end
              OP_DIV, OP_DIVU: begin
                if (op_b == '0) begin
                  done_reg     <= 1'b1;
                  div_zero_reg <= 1'b1;
                  state_reg    <= S_DONE;
                end else begin
                  acc_reg    <= {{WIDTH{1'b0}}, abs_a};
                  m_reg      <= abs_b;
                  cnt_reg    <= '0;
                  is_div_reg <= 1'b1;
                  sign_a_reg <= req_signed && op_a[WIDTH-1];
                  sign_b_reg <= req_signed && op_b[WIDTH-1];
                  busy_reg   <= 1'b1;
                  state_reg  <= S_RUN;
                end
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          acc_reg <= step_next;
          if (cnt_reg == LAST) begin
            cnt_reg   <= '0;
            state_reg <= S_FIX;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_FIX: begin
          if (is_div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quot_fix;
          end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= S_DONE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign div_zero = div_zero_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule

// File: tb/tb_mips_cpu_bus_muldiv_unit.sv
// Directed bench for the mult/div unit at WIDTH=32 with hand-computed results.
module tb_mips_cpu_bus_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [4:0]  control_alu = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  int lat;
  logic dz, sb, saw_done;

  mips_cpu_bus_muldiv_unit #(.WIDTH(32), .CW(5)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .control_alu(control_alu),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present a request for one cycle; returns #1 after the accept edge.
  task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1; control_alu = code; op_a = a; op_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
  endtask

  // lat is the index of the cycle after the accept edge in which done is seen.
  task automatic wait_done(input string tag, output int l, output logic d, output logic s);
    l = 1; s = busy;
    while (done !== 1'b1 && l < 200) begin
      @(posedge clk); #1;
      l++;
      if (busy) s = 1'b1;
    end
    d = div_zero;
    chk({tag, "_done_seen"}, {63'd0, done}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int l; logic d, s;
    issue(code, a, b);
    wait_done(tag, l, d, s);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_dz", {63'd0, div_zero}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b1;

    // Reset in RUN cycle 10 abandons the multiply.
    issue(5'd7, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset_hilo", {hi, lo}, 64'd0);
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); reset = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("midreset_no_done", {63'd0, saw_done}, 64'd0);
    run_op("multu_7x9", 5'd7, 32'd7, 32'd9, 32'd0, 32'd63);

    // Signed multiply with latency check.
    issue(5'd8, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy", {63'd0, busy}, 64'd1);
    wait_done("mult", lat, dz, sb);
    chk("mult_latency", 64'(lat), 64'd34);
    chk("mult_dz", {63'd0, dz}, 64'd0);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    @(posedge clk); #1;
    chk("idle_after_done", {62'd0, busy, done}, 64'd0);

    run_op("multu_max", 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg_neg", 5'd8, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'd15);
    run_op("div_m7_2", 5'd5, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", 5'd5, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("div_ovf", 5'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("divu_100_7", 5'd4, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_big", 5'd4, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF);

    // Divide by zero leaves HI/LO untouched.
    issue(5'd19, 32'h11, 32'd0);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    issue(5'd18, 32'h22, 32'd0);
    chk("mtlo_hilo", {hi, lo}, {32'h11, 32'h22});
    issue(5'd4, 32'd5, 32'd0);
    wait_done("divz", lat, dz, sb);
    chk("divz_latency", 64'(lat), 64'd1);
    chk("divz_flag", {63'd0, dz}, 64'd1);
    chk("divz_busy_never", {63'd0, sb}, 64'd0);
    chk("divz_hilo", {hi, lo}, {32'h11, 32'h22});
    @(posedge clk); #1;
    chk("divz_flag_cleared", {62'd0, done, div_zero}, 64'd0);

    // Unknown code is ignored.
    issue(5'd2, 32'h77, 32'h1);
    chk("bad_code_hilo", {hi, lo}, {32'h11, 32'h22});

    // Requests while busy or in DONE are dropped.
    issue(5'd7, 32'd3, 32'd4);
    repeat (3) @(posedge clk);
    issue(5'd19, 32'hAA, 32'd0);
    wait_done("multu_3x4", lat, dz, sb);
    chk("busy_ignore_hilo", {hi, lo}, {32'd0, 32'd12});
    @(negedge clk);
    op_valid = 1'b1; control_alu = 5'd18; op_a = 32'h55;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("done_ignore_lo", {32'd0, lo}, 64'd12);
    issue(5'd19, 32'hAA, 32'd0);
    chk("mthi_after_done", {32'd0, hi}, 64'hAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus_muldiv_unit.md
Name: mips_cpu_bus_muldiv_unit

Overview:
Iterative multiply/divide unit owning the HI/LO register pair. It is driven by the ALU control codes (4 DIVU, 5 DIV, 7 MULTU, 8 MULT, 18 MTLO, 19 MTHI) and sits beside the ALU in the execute stage. It stalls the bus CPU through `busy` and reports completion with a one-cycle `done`. It is width-parametrised so the same block serves the 32-bit core and narrow unit-level benches.

Parameters:
WIDTH, 32, operand/HI/LO width; legal range 4..64.
CW, 5, control code width; matches the ALU control output.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low (0 = reset); deassertion synchronous to clk by the system
op_valid  input  1  request strobe, qualified with control_alu
control_alu  input  CW  operation code (4,5,7,8,18,19; all others ignored)
op_a  input  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO source)
op_b  input  WIDTH  rt value (divisor / multiplier)
busy  output  1  high while a mult/div is in flight; CPU stalls on it
done  output  1  one-cycle pulse: HI/LO hold a new mult/div result
div_zero  output  1  one-cycle pulse with done when the divisor was 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, reset=0): state=IDLE; hi=lo=0; busy=done=div_zero=0; iteration counter=0; all operand/sign latches=0. A reset asserted mid-operation abandons the op with no done pulse.
- Accept: a request is taken on a rising edge with op_valid=1 and state=IDLE. Requests with op_valid=1 while not in IDLE are ignored; there is no queue, and the CPU must hold the request until it sees busy=0. Codes outside the list are ignored.
- MTHI/MTLO: on the accept edge, hi (or lo) <= op_a. No state change; busy and done stay low. The new value is visible the next cycle.
- States: IDLE -> RUN -> FIX -> DONE -> IDLE.
  - IDLE -> RUN on accepting 4/5/7/8 with divisor != 0 (or any mult). Latch |op_a| and |op_b| (signed codes) or the raw values (unsigned codes). Latch op, sign_a, sign_b. counter=0.
  - IDLE -> DONE on accepting 4/5 with op_b==0. hi and lo stay unchanged; done=1 and div_zero=1 in DONE.
  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle, for exactly WIDTH cycles (counter 0..WIDTH-1). The 2*WIDTH accumulator holds the partial product, or remainder:quotient. Then go to FIX.
  - FIX: apply sign correction and write hi/lo on the exiting edge.
    - MULT: negate the 2*WIDTH product if sign_a!=sign_b; hi=upper, lo=lower.
    - DIV: negate quotient if sign_a!=sign_b; remainder takes sign_a.
    - All divides: lo=quotient, hi=remainder.
    - Unsigned ops apply no correction.
  - DONE: done=1 for exactly one cycle, then IDLE. A new request can be accepted on the DONE->IDLE edge only if state is IDLE at that edge, i.e. the cycle after done.
- busy = 1 in RUN and FIX, 0 in IDLE and DONE.
- Latency: accept edge -> done high = WIDTH+2 cycles (WIDTH RUN + FIX + DONE). Divide-by-zero: 1 cycle.
- Overflow case: DIV of most-negative by -1 gives lo = most-negative (wraps), hi=0, no flag.
- All arithmetic is modulo 2^WIDTH per register. Operands are sampled only at accept; later changes on op_a/op_b have no effect.

Test Plan:
- Reset mid-RUN: start MULTU 7x9, pull reset low at RUN cycle 10 -> hi=lo=0, busy=0, no done pulse; next MULTU 7x9 -> lo=63, hi=0.
- MULT signed, WIDTH=32: op_a=0xFFFFFFFE (-2), op_b=3 -> done exactly 34 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 100/7 -> lo=14, hi=2.
- Divide by zero: preload hi=0x11 and lo=0x22 via MTHI/MTLO, then DIVU 5/0 -> next cycle done=1, div_zero=1, busy never high; hi=0x11, lo=0x22.
- Ignore while busy: start MULTU 3x4, pulse op_valid with MTHI op_a=0xAA during RUN -> ignored; lo=12, hi=0. MTHI 0xAA accepted in the cycle after done -> hi=0xAA.
